// File: rtl/parking_lane_scheduler_pkg.sv
// Shared types and defaults for the parking-lane access scheduler.
package parking_lane_scheduler_pkg;

  localparam int unsigned DefaultPinW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWaitPin,
    StCheck,
    StRelease
  } state_e;

endpackage

// File: rtl/parking_lane_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module parking_lane_scheduler_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned     j;
    logic [IdxW-1:0] j_idx;
    j       = 0;
    j_idx   = '0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j     = (32'(ptr_i) + i) % N;
      j_idx = IdxW'(j);
      if (!valid_o && req_i[j_idx]) begin
        valid_o        = 1'b1;
        grant_o[j_idx] = 1'b1;
        idx_o          = j_idx;
      end
    end
  end

endmodule

// File: rtl/parking_lane_scheduler.sv
// Shares one PIN-check/gate access unit between several entry lanes, round-robin,
// and tracks how many cars are in the lot.
module parking_lane_scheduler
  import parking_lane_scheduler_pkg::*;
#(
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned PIN_W       = DefaultPinW,
  parameter int unsigned CAPACITY    = 64,
  parameter int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned IdxW = $clog2(N_LANES),
  localparam int unsigned OccW = $clog2(CAPACITY + 1),
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [N_LANES-1:0]       lane_arrival_i,
  input  logic [N_LANES-1:0]       lane_pin_valid_i,
  input  logic [N_LANES*PIN_W-1:0] lane_pin_i,
  input  logic                     vehicle_exit_i,
  input  logic                     acc_done_i,
  input  logic                     acc_ok_i,
  input  logic                     acc_blocked_i,
  output logic [N_LANES-1:0]       lane_grant_o,
  output logic                     acc_start_o,
  output logic [PIN_W-1:0]         acc_clave_o,
  output logic [N_LANES-1:0]       lane_timeout_o,
  output logic [OccW-1:0]          occupancy_o,
  output logic                     lot_full_o
);

  state_e               state_q, state_d;
  logic [N_LANES-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [TmrW-1:0]      timer_q, timer_d;
  logic [PIN_W-1:0]     clave_q, clave_d;
  logic                 start_q, start_d;
  logic [N_LANES-1:0]   tout_q, tout_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic                 full_q, full_d;

  logic [N_LANES-1:0]   arb_grant;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_valid;

  parking_lane_scheduler_rr_arbiter #(
    .N (N_LANES)
  ) u_arb (
    .req_i   (lane_arrival_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Grant FSM: next state, grant/PIN latch, wait timer and one-cycle pulses.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    clave_d = clave_q;
    start_d = 1'b0;
    tout_d  = '0;
    unique case (state_q)
      StIdle: begin
        // Full lot or locked-out unit only blocks new grants here.
        if (arb_valid && !full_q && !acc_blocked_i) begin
          grant_d = arb_grant;
          idx_d   = arb_idx;
          timer_d = '0;
          state_d = StWaitPin;
        end
      end
      StWaitPin: begin
        // PIN beats a coincident timeout.
        if (lane_pin_valid_i[idx_q]) begin
          clave_d = lane_pin_i[idx_q*PIN_W +: PIN_W];
          start_d = 1'b1;
          state_d = StCheck;
        end else if (timer_q == TmrW'(TIMEOUT_CYC - 1)) begin
          tout_d  = grant_q;
          grant_d = '0;
          state_d = StRelease;
        end else if (!lane_arrival_i[idx_q]) begin
          grant_d = '0;
          state_d = StRelease;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCheck: begin
        if (acc_done_i) begin
          grant_d = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        ptr_d   = (idx_q == IdxW'(N_LANES - 1)) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy: saturating up/down count; simultaneous entry and exit cancel.
  always_comb begin
    logic inc;
    inc   = acc_done_i && acc_ok_i;
    occ_d = occ_q;
    if (inc && !vehicle_exit_i && occ_q != OccW'(CAPACITY)) begin
      occ_d = occ_q + 1'b1;
    end else if (vehicle_exit_i && !inc && occ_q != '0) begin
      occ_d = occ_q - 1'b1;
    end
    full_d = (occ_d == OccW'(CAPACITY));
  end

  // State register with synchronous reset; reset aborts any transaction silently.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      clave_q <= '0;
      start_q <= 1'b0;
      tout_q  <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      clave_q <= clave_d;
      start_q <= start_d;
      tout_q  <= tout_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
    end
  end

  assign lane_grant_o   = grant_q;
  assign acc_start_o    = start_q;
  assign acc_clave_o    = clave_q;
  assign lane_timeout_o = tout_q;
  assign occupancy_o    = occ_q;
  assign lot_full_o     = full_q;

endmodule

// File: tb/tb_parking_lane_scheduler.sv
// Bench for parking_lane_scheduler: scripted table, corner sequences, random vs model.
module tb_parking_lane_scheduler;

  localparam int NL  = 4;
  localparam int PW  = 16;
  localparam int CAP = 4;
  localparam int TMO = 16;
  localparam int OW  = $clog2(CAP + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [NL-1:0]   arr, pinv;
  logic [NL*PW-1:0] pins;
  logic            vexit, done, ok, blocked;
  logic [NL-1:0]   lane_grant, lane_timeout;
  logic            acc_start, lot_full;
  logic [PW-1:0]   acc_clave;
  logic [OW-1:0]   occupancy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (transaction-level view of the scheduler).
  int          m_owner = -1;
  int          m_wait = 0;
  int          m_ptr = 0;
  int          m_occ = 0;
  bit          m_release = 0;
  bit          m_checking = 0;
  bit          m_full = 0;
  bit          exp_start = 0;
  logic [PW-1:0] m_clave = '0;
  logic [NL-1:0] exp_tout = '0;
  logic [NL-1:0] exp_grant = '0;

  parking_lane_scheduler #(
    .N_LANES     (NL),
    .PIN_W       (PW),
    .CAPACITY    (CAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .lane_arrival_i   (arr),
    .lane_pin_valid_i (pinv),
    .lane_pin_i       (pins),
    .vehicle_exit_i   (vexit),
    .acc_done_i       (done),
    .acc_ok_i         (ok),
    .acc_blocked_i    (blocked),
    .lane_grant_o     (lane_grant),
    .acc_start_o      (acc_start),
    .acc_clave_o      (acc_clave),
    .lane_timeout_o   (lane_timeout),
    .occupancy_o      (occupancy),
    .lot_full_o       (lot_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge.
  task automatic model_step();
    bit old_full;
    bit inc;
    int lane;
    if (rst) begin
      m_owner = -1; m_wait = 0; m_ptr = 0; m_occ = 0;
      m_release = 0; m_checking = 0; m_full = 0;
      m_clave = '0; exp_start = 0; exp_tout = '0;
    end else begin
      old_full  = m_full;
      inc       = done && ok;
      exp_start = 0;
      exp_tout  = '0;
      if (inc && !vexit && m_occ < CAP) m_occ++;
      else if (vexit && !inc && m_occ > 0) m_occ--;
      m_full = (m_occ == CAP);
      if (m_release) begin
        m_ptr = (m_owner + 1) % NL;
        m_owner = -1;
        m_release = 0;
        m_checking = 0;
      end else if (m_owner < 0) begin
        if (arr != '0 && !old_full && !blocked) begin
          for (int k = 0; k < NL; k++) begin
            lane = (m_ptr + k) % NL;
            if (m_owner < 0 && arr[lane]) begin
              m_owner = lane;
              m_wait = 0;
            end
          end
        end
      end else if (!m_checking) begin
        if (pinv[m_owner]) begin
          m_clave = pins[m_owner*PW +: PW];
          exp_start = 1;
          m_checking = 1;
        end else if (m_wait == TMO - 1) begin
          exp_tout[m_owner] = 1'b1;
          m_release = 1;
        end else if (!arr[m_owner]) begin
          m_release = 1;
        end else begin
          m_wait++;
        end
      end else if (done) begin
        m_release = 1;
      end
    end
    exp_grant = (m_owner >= 0 && !m_release) ? NL'(1 << m_owner) : '0;
  endtask

  task automatic check_model();
    chk("model_grant", 64'(lane_grant), 64'(exp_grant));
    chk("model_acc_start", 64'(acc_start), 64'(exp_start));
    chk("model_acc_clave", 64'(acc_clave), 64'(m_clave));
    chk("model_lane_timeout", 64'(lane_timeout), 64'(exp_tout));
    chk("model_occupancy", 64'(occupancy), 64'(m_occ));
    chk("model_lot_full", 64'(lot_full), 64'(m_full));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic clear_pulses();
    pinv = '0; done = 1'b0; ok = 1'b0; vexit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; arr = '0; blocked = 1'b0;
    clear_pulses();
    tick();
    tick();
    chk("rst_grant", 64'(lane_grant), 64'(0));
    chk("rst_acc_start", 64'(acc_start), 64'(0));
    chk("rst_acc_clave", 64'(acc_clave), 64'(0));
    chk("rst_timeout", 64'(lane_timeout), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_lot_full", 64'(lot_full), 64'(0));
    rst = 1'b0;
  endtask

  // Bounded wait for any grant, then compare it with the expected one-hot.
  task automatic wait_grant(input string name, input logic [NL-1:0] exp, input int budget);
    int i;
    i = 0;
    while (lane_grant == '0 && i < budget) begin
      tick();
      i++;
    end
    chk(name, 64'(lane_grant), 64'(exp));
  endtask

  typedef struct {
    logic [NL-1:0] arr;
    logic [NL-1:0] pinv;
    logic          done;
    logic          ok;
    logic [NL-1:0] e_grant;
    logic          e_start;
    logic [PW-1:0] e_clave;
    logic [OW-1:0] e_occ;
  } vec_t;

  vec_t tbl [10];
  logic [NL-1:0] order [4];
  logic [PW-1:0] order_pin [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arr = '0; blocked = 1'b0; clear_pulses();
    pins = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    // Test 1: lane 2, PIN three cycles after grant, accepted five cycles after start.
    tbl[0] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h0000, 3'd0};
    tbl[1] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h0000, 3'd0};
    tbl[2] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h0000, 3'd0};
    tbl[3] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 16'h3333, 3'd0};
    tbl[4] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h3333, 3'd0};
    tbl[5] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h3333, 3'd0};
    tbl[6] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h3333, 3'd0};
    tbl[7] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h3333, 3'd0};
    tbl[8] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h3333, 3'd1};
    tbl[9] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h3333, 3'd1};

    do_reset();
    for (int r = 0; r < 10; r++) begin
      arr = tbl[r].arr; pinv = tbl[r].pinv; done = tbl[r].done; ok = tbl[r].ok;
      tick();
      chk($sformatf("t1_grant[%0d]", r), 64'(lane_grant), 64'(tbl[r].e_grant));
      chk($sformatf("t1_start[%0d]", r), 64'(acc_start), 64'(tbl[r].e_start));
      chk($sformatf("t1_clave[%0d]", r), 64'(acc_clave), 64'(tbl[r].e_clave));
      chk($sformatf("t1_occ[%0d]", r), 64'(occupancy), 64'(tbl[r].e_occ));
    end
    clear_pulses();

    // Test 2: lanes 0,1,3 together; lane 0 re-requests and is served after lane 3.
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0001;
    order_pin[0] = 16'h1111; order_pin[1] = 16'h2222;
    order_pin[2] = 16'h4444; order_pin[3] = 16'h1111;
    do_reset();
    arr = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("t2_grant[%0d]", k), order[k], 8);
      pinv = order[k];
      tick();
      pinv = '0;
      chk($sformatf("t2_start[%0d]", k), 64'(acc_start), 64'(1));
      chk($sformatf("t2_clave[%0d]", k), 64'(acc_clave), 64'(order_pin[k]));
      done = 1'b1; ok = 1'b0;
      tick();
      done = 1'b0;
      chk($sformatf("t2_release[%0d]", k), 64'(lane_grant), 64'(0));
      if (k != 0) arr = arr & ~order[k];
      tick();
      chk($sformatf("t2_gap[%0d]", k), 64'(lane_grant), 64'(0));
    end
    chk("t2_occ_reject", 64'(occupancy), 64'(0));

    // Test 3: lane 1 times out; then a PIN on the exact timeout cycle wins.
    do_reset();
    arr = 4'b0010;
    wait_grant("t3_grant", 4'b0010, 4);
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      chk("t3_no_timeout_yet", 64'(lane_timeout), 64'(0));
    end
    tick();
    chk("t3_timeout_pulse", 64'(lane_timeout), 64'(4'b0010));
    chk("t3_timeout_grant", 64'(lane_grant), 64'(0));
    chk("t3_timeout_nostart", 64'(acc_start), 64'(0));
    tick();
    chk("t3_timeout_1cyc", 64'(lane_timeout), 64'(0));
    wait_grant("t3_regrant", 4'b0010, 4);
    for (int i = 0; i < TMO - 1; i++) tick();
    pinv = 4'b0010;
    tick();
    pinv = '0;
    chk("t3_pin_wins_start", 64'(acc_start), 64'(1));
    chk("t3_pin_wins_notout", 64'(lane_timeout), 64'(0));
    done = 1'b1;
    tick();
    done = 1'b0; arr = '0;
    tick();

    // Test 4: fill the lot, blocked grants, exit resumes, simultaneous entry/exit.
    do_reset();
    ok = 1'b1; done = 1'b1;
    for (int i = 0; i < CAP - 1; i++) tick();
    done = 1'b0;
    chk("t4_occ_pre", 64'(occupancy), 64'(CAP - 1));
    arr = 4'b0001;
    wait_grant("t4_grant", 4'b0001, 4);
    pinv = 4'b0001;
    tick();
    pinv = '0; done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_occ_full", 64'(occupancy), 64'(CAP));
    chk("t4_lot_full", 64'(lot_full), 64'(1));
    arr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_no_grant_full", 64'(lane_grant), 64'(0));
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_saturate_high", 64'(occupancy), 64'(CAP));
    vexit = 1'b1;
    tick();
    vexit = 1'b0;
    chk("t4_exit_occ", 64'(occupancy), 64'(CAP - 1));
    chk("t4_exit_not_full", 64'(lot_full), 64'(0));
    wait_grant("t4_resume", 4'b0010, 4);
    done = 1'b1; vexit = 1'b1;
    tick();
    done = 1'b0; vexit = 1'b0;
    chk("t4_entry_exit_same", 64'(occupancy), 64'(CAP - 1));
    pinv = 4'b0010;
    tick();
    pinv = '0; ok = 1'b0; done = 1'b1;
    tick();
    done = 1'b0; arr = '0;
    tick();
    tick();

    // Test 5: lock-out during CHECK lets the transaction finish, then stalls grants.
    do_reset();
    arr = 4'b0001;
    wait_grant("t5_grant", 4'b0001, 4);
    pinv = 4'b0001;
    tick();
    pinv = '0; blocked = 1'b1; arr = 4'b0011;
    tick();
    tick();
    chk("t5_check_held", 64'(lane_grant), 64'(4'b0001));
    done = 1'b1; ok = 1'b0;
    tick();
    done = 1'b0;
    chk("t5_finished", 64'(lane_grant), 64'(0));
    chk("t5_reject_occ", 64'(occupancy), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_blocked_no_grant", 64'(lane_grant), 64'(0));
    end
    blocked = 1'b0;
    wait_grant("t5_unblocked", 4'b0010, 4);

    // Test 6: reset in CHECK clears everything; exit at empty lot stays at zero.
    pinv = 4'b0010; done = 1'b1; ok = 1'b1;
    tick();
    pinv = '0; done = 1'b0;
    chk("t6_start", 64'(acc_start), 64'(1));
    chk("t6_clave", 64'(acc_clave), 64'(16'h2222));
    chk("t6_occ_before", 64'(occupancy), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; arr = '0;
    chk("t6_rst_grant", 64'(lane_grant), 64'(0));
    chk("t6_rst_clave", 64'(acc_clave), 64'(0));
    chk("t6_rst_occ", 64'(occupancy), 64'(0));
    chk("t6_rst_start", 64'(acc_start), 64'(0));
    vexit = 1'b1;
    tick();
    vexit = 1'b0;
    chk("t6_exit_at_zero", 64'(occupancy), 64'(0));

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 11) == 0) arr[l] = ~arr[l];
        pinv[l] = ($urandom_range(0, (c < 2000) ? 5 : 40) == 0);
      end
      pins    = {$urandom, $urandom};
      done    = ($urandom_range(0, 4) == 0);
      ok      = ($urandom_range(0, 1) == 1);
      vexit   = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 39) == 0) blocked = ~blocked;
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
